// File: rtl/uart_mem_dump.sv
// Reads a block of 32-bit words from data memory and streams them out of the
// board UART TX pin as 8N1 bytes, little-endian byte order, LSB-first bits.
module uart_mem_dump #(
  parameter int CLK_FREQ = 23_000_000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 14
) (
  input  logic              cpuclk,
  input  logic              rst_n,
  input  logic              dump_start,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W:0]   dump_len,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_data_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_NEXT
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [31:0]       shift;
  logic [CNT_W-1:0]  baud_cnt;
  logic [2:0]        bit_idx;
  logic [1:0]        byte_idx;

  logic bit_end;
  logic last_word;
  logic on_line;

  assign bit_end    = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  // A zero-length request also lands in ST_NEXT, so "<= 1" finishes it
  // without decrementing remaining below zero.
  assign last_word  = (remaining <= (ADDR_W+1)'(1));
  assign on_line    = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
  assign mem_addr_o = addr;

  // NOTE: every output and state_next gets a default before the case so no
  // path through this block can leave a variable unassigned and infer a latch.
  always_comb begin
    state_next = state;
    mem_rd_o   = 1'b0;
    tx_o       = 1'b1;
    done_o     = 1'b0;
    busy_o     = (state != ST_IDLE);

    unique case (state)
      ST_IDLE: begin
        if (dump_start) begin
          state_next = (dump_len == '0) ? ST_NEXT : ST_RD;
        end
      end
      ST_RD: begin
        mem_rd_o   = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        state_next = ST_START;
      end
      ST_START: begin
        tx_o = 1'b0;
        if (bit_end) state_next = ST_DATA;
      end
      ST_DATA: begin
        tx_o = shift[0];
        if (bit_end && (bit_idx == 3'd7)) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) state_next = (byte_idx == 2'd3) ? ST_NEXT : ST_START;
      end
      ST_NEXT: begin
        done_o     = last_word;
        state_next = last_word ? ST_IDLE : ST_RD;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge (synchronous), so it wins over
  // every other branch simply by being the outermost if.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge cpuclk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      shift     <= '0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
    end else begin
      state <= state_next;

      if (on_line) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
      end

      unique case (state)
        ST_IDLE: begin
          if (dump_start) begin
            addr      <= dump_base;
            remaining <= dump_len;
          end
        end
        ST_WAIT: begin
          shift    <= mem_data_i;
          byte_idx <= '0;
          bit_idx  <= '0;
          baud_cnt <= '0;
        end
        ST_DATA: begin
          // The 32-bit word shifts continuously, so after byte N its bit 0
          // is already the first bit of byte N+1.
          if (bit_end) begin
            shift   <= {1'b1, shift[31:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
        ST_STOP: begin
          if (bit_end && (byte_idx != 2'd3)) byte_idx <= byte_idx + 2'd1;
        end
        ST_NEXT: begin
          addr      <= addr + ADDR_W'(1);
          remaining <= last_word ? '0 : remaining - (ADDR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_dump.sv
// Directed bench for uart_mem_dump: memory model, UART line receiver and
// hand-computed byte streams, read addresses and busy durations.
module tb_uart_mem_dump;

  localparam int CPB      = 199;
  localparam int WORD_CYC = 40 * CPB + 3;

  logic        cpuclk = 1'b0;
  logic        rst_n;
  logic        dump_start;
  logic [13:0] dump_base;
  logic [14:0] dump_len;
  logic        mem_rd_o;
  logic [13:0] mem_addr_o;
  logic [31:0] mem_data_i = '0;
  logic        tx_o;
  logic        busy_o;
  logic        done_o;

  always #5 cpuclk = ~cpuclk;

  uart_mem_dump dut (
    .cpuclk     (cpuclk),
    .rst_n      (rst_n),
    .dump_start (dump_start),
    .dump_base  (dump_base),
    .dump_len   (dump_len),
    .mem_rd_o   (mem_rd_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_i (mem_data_i),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: data valid exactly one cycle after the read strobe.
  logic [31:0] mem [0:16383];
  always @(posedge cpuclk) if (mem_rd_o) mem_data_i <= mem[mem_addr_o];

  logic [13:0] rd_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  int          done_cnt   = 0;
  int          tx_low_cnt = 0;

  always @(negedge cpuclk) begin
    if (mem_rd_o) rd_q.push_back(mem_addr_o);
    if (done_o) done_cnt++;
    if (tx_o !== 1'b1) tx_low_cnt++;
  end

  // Line receiver: samples the middle of each bit.
  initial begin
    forever begin : rx_loop
      logic [7:0] b;
      @(negedge cpuclk);
      if (rst_n === 1'b1 && tx_o === 1'b0) begin
        repeat (CPB / 2) @(negedge cpuclk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge cpuclk);
          b[i] = tx_o;
        end
        repeat (CPB) @(negedge cpuclk);
        check("stop_bit", {31'd0, tx_o}, 32'd1);
        rx_q.push_back(b);
      end
    end
  end

  task automatic clear_logs();
    rd_q.delete();
    rx_q.delete();
    exp_q.delete();
    done_cnt   = 0;
    tx_low_cnt = 0;
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[31:24]);
  endtask

  task automatic check_stream(input string tag);
    check($sformatf("%s_nbytes", tag), rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
  endtask

  task automatic check_reads(input string tag, input logic [13:0] exp_a[$]);
    check($sformatf("%s_nreads", tag), rd_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < rd_q.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), {18'd0, rd_q[i]}, {18'd0, exp_a[i]});
  endtask

  // Issues one request and waits for done_o; optionally fires a second
  // request mid-dump (inject_at > 0) or in the done_o cycle.
  task automatic run_dump(input logic [13:0] base, input logic [14:0] len,
                          input int inject_at, input bit start_at_done,
                          output int busy_cycles);
    bit seen;
    seen = 1'b0;
    @(negedge cpuclk);
    dump_start = 1'b1;
    dump_base  = base;
    dump_len   = len;
    @(negedge cpuclk);
    dump_start = 1'b0;
    dump_base  = ~base;
    dump_len   = len + 15'd5;
    busy_cycles = 0;
    for (int c = 0; c < int'(len) * WORD_CYC + 50; c++) begin
      if (busy_o === 1'b1) busy_cycles++;
      if (done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      dump_start = (inject_at > 0) && (c == inject_at);
      if (dump_start) begin
        dump_base = 14'h0020;
        dump_len  = 15'd2;
      end
      @(negedge cpuclk);
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    dump_start = start_at_done;
    @(negedge cpuclk);
    dump_start = 1'b0;
    check("busy_drop", {31'd0, busy_o}, 32'd0);
    repeat (5) @(negedge cpuclk);
    check("busy_stays_low", {31'd0, busy_o}, 32'd0);
  endtask

  int bc;
  logic [13:0] exp_a[$];

  initial begin
    rst_n      = 1'b0;
    dump_start = 1'b0;
    dump_base  = '0;
    dump_len   = '0;
    repeat (3) @(negedge cpuclk);
    check("rst_tx",   {31'd0, tx_o},     32'd1);
    check("rst_busy", {31'd0, busy_o},   32'd0);
    check("rst_done", {31'd0, done_o},   32'd0);
    check("rst_rd",   {31'd0, mem_rd_o}, 32'd0);
    check("rst_addr", {18'd0, mem_addr_o}, 32'd0);
    rst_n = 1'b1;

    // Idle line after reset.
    clear_logs();
    repeat (1000) @(negedge cpuclk);
    check("idle_tx_low", tx_low_cnt, 0);
    check("idle_done",   done_cnt,   0);

    // Single word; a start in the done_o cycle must be ignored.
    clear_logs();
    mem[0] = 32'h1234_5678;
    push_word(32'h1234_5678);
    run_dump(14'h0000, 15'd1, 0, 1'b1, bc);
    check("w1_busy_cycles", bc, WORD_CYC);
    check("w1_done_cnt", done_cnt, 1);
    exp_a = '{14'h0000};
    check_reads("w1", exp_a);
    check_stream("w1");

    // Zero-length request.
    clear_logs();
    run_dump(14'h0123, 15'd0, 0, 1'b0, bc);
    check("len0_busy_cycles", bc, 1);
    check("len0_done_cnt", done_cnt, 1);
    check("len0_nreads", rd_q.size(), 0);
    check("len0_tx_low", tx_low_cnt, 0);

    // Address wrap across the top of memory.
    clear_logs();
    mem[14'h3FFE] = 32'hA1B2_C3D4;
    mem[14'h3FFF] = 32'h0BAD_F00D;
    mem[14'h0000] = 32'hCAFE_0001;
    push_word(32'hA1B2_C3D4);
    push_word(32'h0BAD_F00D);
    push_word(32'hCAFE_0001);
    run_dump(14'h3FFE, 15'd3, 0, 1'b0, bc);
    check("wrap_busy_cycles", bc, 3 * WORD_CYC);
    check("wrap_done_cnt", done_cnt, 1);
    exp_a = '{14'h3FFE, 14'h3FFF, 14'h0000};
    check_reads("wrap", exp_a);
    check_stream("wrap");

    // Second request mid-dump is ignored.
    clear_logs();
    mem[14'h0010] = 32'hA5C3_0F81;
    mem[14'h0020] = 32'h1111_1111;
    mem[14'h0021] = 32'h2222_2222;
    push_word(32'hA5C3_0F81);
    run_dump(14'h0010, 15'd1, 3000, 1'b0, bc);
    check("ign_busy_cycles", bc, WORD_CYC);
    check("ign_done_cnt", done_cnt, 1);
    exp_a = '{14'h0010};
    check_reads("ign", exp_a);
    check_stream("ign");

    // Reset during data bit 1 of byte 2 (0xAD -> bit1 = 0).
    clear_logs();
    mem[14'h0040] = 32'hDEAD_BEEF;
    mem[14'h0041] = 32'h55AA_55AA;
    @(negedge cpuclk);
    dump_start = 1'b1;
    dump_base  = 14'h0040;
    dump_len   = 15'd2;
    @(negedge cpuclk);
    dump_start = 1'b0;
    repeat (4480) @(negedge cpuclk);
    check("rst_mid_bit", {31'd0, tx_o}, 32'd0);
    rst_n = 1'b0;
    @(negedge cpuclk);
    rst_n = 1'b1;
    check("rst_mid_tx",   {31'd0, tx_o},   32'd1);
    check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    check("rst_mid_done", done_cnt, 0);
    repeat (2200) @(negedge cpuclk);
    check("rst_mid_quiet_busy", {31'd0, busy_o}, 32'd0);
    clear_logs();
    push_word(32'hDEAD_BEEF);
    run_dump(14'h0040, 15'd1, 0, 1'b0, bc);
    check("rst_new_busy_cycles", bc, WORD_CYC);
    check("rst_new_done_cnt", done_cnt, 1);
    exp_a = '{14'h0040};
    check_reads("rst_new", exp_a);
    check_stream("rst_new");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
